stepper_phase_sequencer: RTL and testbench
==========================================

Name: stepper_phase_sequencer

Overview:
- Consumes the periodic step tick from the cycle counter (its carry_out) and drives the four coil lines of a unipolar/bipolar stepper through full-step or half-step phase patterns.
- Runs a commanded number of steps in a commanded direction, tracks absolute position, and reports busy/done to the control logic.
- Sits between the step-rate counter and the coil driver pins.

Parameters:
- HOLD_TORQUE, 1, 1 = coils stay energised on last pattern while idle; 0 = coils forced to 4'b0000 while idle.
- STEP_W, 32, width of num_steps and remaining-step counter.
- POS_W, 32, width of the position counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- step_tick  in  1  step strobe from cycle counter; every clk cycle sampled high = one step request.
- start  in  1  launch a move; sampled only in IDLE.
- abort  in  1  stop current move immediately.
- dir  in  1  1 = forward (index increments), 0 = reverse; latched at start.
- half_step  in  1  1 = half-step mode, 0 = full-step; latched at start.
- num_steps  in  STEP_W  steps to execute; latched at start.
- coils  out  4  coil drive pattern {A,B,C,D}.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- position  out  POS_W  signed absolute step count, two's complement.

Behaviour:
- Async reset: state=IDLE, phase index=0, coils=4'b0000, busy=0, done=0, position=0, remaining=0, latched dir/mode=0.
- Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Half-step mode: each step moves the index ±1 (mod 8).
- Full-step mode: from an odd index, each step moves ±2 (mod 8). From an even index, the first step moves ±1 to align to a two-coil pattern.
- States:
  - IDLE: start=1 latches num_steps/dir/half_step. num_steps==0 -> DONE; else -> RUN.
  - RUN: each cycle with step_tick=1 advances the index, updates position (+1 forward / -1 reverse, wraps modulo 2^POS_W) and decrements remaining. The tick that takes remaining 1->0 -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency:
  - start at edge N -> busy=1 after edge N.
  - step_tick high before edge M -> new coils and position visible after edge M.
  - Final step's coil update and done=1 appear after the same edge.
- In IDLE and DONE: coils = table[index] if HOLD_TORQUE=1, else 4'b0000. In RUN: coils = table[index] always.
- step_tick ignored in IDLE/DONE. start ignored in RUN/DONE. num_steps/dir/half_step changes during RUN have no effect.
- abort in RUN -> IDLE on the next edge, no done pulse, remaining cleared, index/position keep their last values. abort has priority over a simultaneous step_tick; that tick is not executed. abort in IDLE/DONE has no effect.
- start and abort together in IDLE: start wins (abort is a no-op in IDLE).
- step_tick held high continuously (counter programmed to 0) = one step per clk.
- rst asserted mid-move clears everything immediately, coils go to 0000 without waiting for clk.

Test Plan:
- Reset, then start with num_steps=4, dir=1, half_step=1, ticks every 5 clk -> coils 1100, 0100, 0110, 0010; position 4; one-cycle done; busy low afterwards.
- From index 0, full-step, dir=0, num_steps=3 -> index 7, 5, 3; coils 1001, 0011, 0110; position -3 (32'hFFFFFFFD).
- start with num_steps=0 -> no busy, done pulse one cycle later, coils and position unchanged.
- step_tick stuck high, num_steps=10 -> 10 consecutive coil changes on 10 consecutive edges, done on the 10th, no extra step.
- abort asserted on the same cycle as the 3rd tick of a 6-step move -> only 2 steps taken, no done, busy drops; a new start is accepted next cycle.
- HOLD_TORQUE=0: coils 0000 in IDLE, pattern during RUN; async rst pulse mid-RUN -> coils 0000 and position 0 without waiting for clk.

Source files
------------

// File: rtl/stepper_phase_sequencer_if.sv
// ============================================================================
//  Module   : stepper_phase_sequencer_if
//  Brief    : Command/status bundle between step-rate logic, controller and
//             the stepper phase sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stepper_phase_sequencer_if #(
    parameter int STEP_W = 32,
    parameter int POS_W  = 32
);
    logic              step_tick;
    logic              start;
    logic              abort;
    logic              dir;
    logic              half_step;
    logic [STEP_W-1:0] num_steps;
    logic [3:0]        coils;
    logic              busy;
    logic              done;
    logic [POS_W-1:0]  position;

    modport master (
        output step_tick, start, abort, dir, half_step, num_steps,
        input  coils, busy, done, position
    );

    modport slave (
        input  step_tick, start, abort, dir, half_step, num_steps,
        output coils, busy, done, position
    );
endinterface

`default_nettype wire

// File: rtl/stepper_phase_sequencer.sv
// ============================================================================
//  Module   : stepper_phase_sequencer
//  Brief    : Full/half-step coil phase sequencer with step count, direction
//             and absolute position tracking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stepper_phase_sequencer #(
    parameter bit HOLD_TORQUE = 1'b1,
    parameter int STEP_W      = 32,
    parameter int POS_W       = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    stepper_phase_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        phase_idx;
    logic [STEP_W-1:0] remaining;
    logic              dir_lat;
    logic              half_lat;
    logic [3:0]        coils_q;
    logic              busy_q;
    logic              done_q;
    logic [POS_W-1:0]  pos_q;

    logic [2:0]        step_size;
    logic [2:0]        next_idx;
    logic [3:0]        idle_coils;
    logic [3:0]        final_coils;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_pattern = 4'b1000;
            3'd1:    phase_pattern = 4'b1100;
            3'd2:    phase_pattern = 4'b0100;
            3'd3:    phase_pattern = 4'b0110;
            3'd4:    phase_pattern = 4'b0010;
            3'd5:    phase_pattern = 4'b0011;
            3'd6:    phase_pattern = 4'b0001;
            default: phase_pattern = 4'b1001;
        endcase
    endfunction

    // Full-step from an even (single-coil) index moves by one to reach a
    // two-coil pattern; after that it strides by two. 3-bit index wraps mod 8.
    always_comb begin
        step_size   = (!half_lat && phase_idx[0]) ? 3'd2 : 3'd1;
        next_idx    = dir_lat ? (phase_idx + step_size) : (phase_idx - step_size);
        idle_coils  = HOLD_TORQUE ? phase_pattern(phase_idx) : 4'b0000;
        final_coils = HOLD_TORQUE ? phase_pattern(next_idx)  : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase_idx <= 3'd0;
            remaining <= '0;
            dir_lat   <= 1'b0;
            half_lat  <= 1'b0;
            coils_q   <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pos_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dir_lat   <= bus.dir;
                        half_lat  <= bus.half_step;
                        remaining <= bus.num_steps;
                        if (bus.num_steps == '0) begin
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            coils_q <= idle_coils;
                        end else begin
                            state   <= S_RUN;
                            busy_q  <= 1'b1;
                            coils_q <= phase_pattern(phase_idx);
                        end
                    end else begin
                        coils_q <= idle_coils;
                    end
                end

                S_RUN: begin
                    // Abort wins over a coincident tick: that step is dropped.
                    if (bus.abort) begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        remaining <= '0;
                        coils_q   <= idle_coils;
                    end else if (bus.step_tick) begin
                        phase_idx <= next_idx;
                        pos_q     <= dir_lat ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                        remaining <= remaining - STEP_W'(1);
                        if (remaining == STEP_W'(1)) begin
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            coils_q <= final_coils;
                        end else begin
                            coils_q <= phase_pattern(next_idx);
                        end
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    coils_q <= idle_coils;
                end

                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    coils_q <= idle_coils;
                end
            endcase
        end
    end

    assign bus.coils    = coils_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.position = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_phase_sequencer.sv
// ============================================================================
//  Module   : tb_stepper_phase_sequencer
//  Brief    : Directed + random bench for both HOLD_TORQUE settings against a
//             step-rule reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stepper_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, step_tick = 1'b0, dir = 1'b0, half_step = 1'b0;
    logic [31:0] num_steps = '0;

    always #5 clk = ~clk;

    stepper_phase_sequencer_if #(.STEP_W(32), .POS_W(32)) bus_h ();
    stepper_phase_sequencer_if #(.STEP_W(32), .POS_W(32)) bus_z ();

    assign bus_h.start = start;      assign bus_z.start = start;
    assign bus_h.abort = abort;      assign bus_z.abort = abort;
    assign bus_h.step_tick = step_tick;  assign bus_z.step_tick = step_tick;
    assign bus_h.dir = dir;          assign bus_z.dir = dir;
    assign bus_h.half_step = half_step;  assign bus_z.half_step = half_step;
    assign bus_h.num_steps = num_steps;  assign bus_z.num_steps = num_steps;

    stepper_phase_sequencer #(.HOLD_TORQUE(1'b1), .STEP_W(32), .POS_W(32)) dut_h (
        .clk(clk), .rst(rst), .bus(bus_h)
    );
    stepper_phase_sequencer #(.HOLD_TORQUE(1'b0), .STEP_W(32), .POS_W(32)) dut_z (
        .clk(clk), .rst(rst), .bus(bus_z)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = idle, 1 = moving, 2 = completion cycle.
    logic [3:0]  pat [8];
    int          m_mode, m_idx, m_left;
    logic [31:0] m_pos;
    logic        m_dir, m_half;
    bit          m_fresh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_left = 0; m_pos = '0;
        m_dir = 1'b0; m_half = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic model_edge();
        int s;
        case (m_mode)
            0: if (start) begin
                m_dir  = dir;
                m_half = half_step;
                if (num_steps == 0) m_mode = 2;
                else begin m_mode = 1; m_left = int'(num_steps); end
            end
            1: if (abort) begin
                m_mode = 0; m_left = 0;
            end else if (step_tick) begin
                s      = (!m_half && (m_idx % 2 == 1)) ? 2 : 1;
                m_idx  = m_dir ? (m_idx + s) % 8 : (m_idx + 8 - s) % 8;
                m_pos  = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
        m_fresh = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_h, exp_z;
        exp_h = m_fresh ? 4'b0000 : pat[m_idx];
        exp_z = (m_fresh || m_mode != 1) ? 4'b0000 : pat[m_idx];
        check("coils_hold",   {28'd0, bus_h.coils}, {28'd0, exp_h});
        check("coils_nohold", {28'd0, bus_z.coils}, {28'd0, exp_z});
        check("busy",         {31'd0, bus_h.busy},  {31'd0, (m_mode == 1)});
        check("done",         {31'd0, bus_h.done},  {31'd0, (m_mode == 2)});
        check("busy_nohold",  {31'd0, bus_z.busy},  {31'd0, (m_mode == 1)});
        check("position",     bus_h.position, m_pos);
        check("position_nohold", bus_z.position, m_pos);
    endtask

    task automatic cycle(input logic st, input logic ab, input logic tk,
                         input logic d, input logic h, input logic [31:0] n);
        @(negedge clk);
        start = st; abort = ab; step_tick = tk; dir = d; half_step = h; num_steps = n;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        pat = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_coils_hold",   {28'd0, bus_h.coils}, 32'd0);
        check("rst_coils_nohold", {28'd0, bus_z.coils}, 32'd0);
        check("rst_busy",         {31'd0, bus_h.busy},  32'd0);
        check("rst_done",         {31'd0, bus_h.done},  32'd0);
        check("rst_position",     bus_h.position,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(1);

        // Forward half-step, 4 steps, tick every 5 clocks; dir input flips during run
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4);
        for (int k = 0; k < 4; k++) begin
            idle(4);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        end
        check("fwd4_final_coils", {28'd0, bus_h.coils}, 32'h2);
        check("fwd4_position", bus_h.position, 32'd4);
        idle(2);

        // Back to index 0 with reverse half-steps
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd99);
        idle(1);

        // Full-step reverse from index 0: 7, 5, 3
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
            idle(1);
        end
        check("rev3_position", bus_h.position, 32'hFFFF_FFFD);
        check("rev3_coils", {28'd0, bus_h.coils}, 32'h6);

        // Zero-length move
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        check("zero_done", {31'd0, bus_h.done}, 32'd1);
        idle(2);

        // step_tick stuck high, 10 steps, no extra step afterwards
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10);
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        check("stuck_position", bus_h.position, 32'd7);

        // Abort coincident with 3rd tick of a 6-step move, then immediate restart
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd6);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        check("abort_position", bus_h.position, 32'd9);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        check("restart_busy", {31'd0, bus_h.busy}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            cycle(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 15) == 0),
                  logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), 32'($urandom_range(0, 5)));
        end
        idle(2);

        // Asynchronous reset in the middle of a move
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_coils_hold",   {28'd0, bus_h.coils}, 32'd0);
        check("arst_coils_nohold", {28'd0, bus_z.coils}, 32'd0);
        check("arst_position",     bus_z.position,       32'd0);
        check("arst_busy",         {31'd0, bus_z.busy},  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0; step_tick = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
